// File: rtl/seg_display_pkg.sv
// Shared definitions for the 7-segment scan output stage.
//   - source encodings for the four displayed CPU words
//   - display geometry constants
//   - segment payload struct and hex-to-segment decoder (active-low g..a)
package seg_display_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned DIGIT_W    = 3;
    localparam int unsigned NIBBLE_W   = 4;
    localparam int unsigned SRC_W      = 2;

    typedef enum logic [SRC_W-1:0] {
        SRC_LED    = 2'd0,
        SRC_ALL    = 2'd1,
        SRC_BRANCH = 2'd2,
        SRC_JMP    = 2'd3
    } src_e;

    // Cathode payload: decimal point on top, then g,f,e,d,c,b,a; all active-low.
    typedef struct packed {
        logic       dp;
        logic [6:0] segs;
    } seg_t;

    // Standard hex glyphs, active-low, bit order g,f,e,d,c,b,a.
    function automatic logic [6:0] hex_to_seg(input logic [NIBBLE_W-1:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h40;
            4'h1:    pat = 7'h79;
            4'h2:    pat = 7'h24;
            4'h3:    pat = 7'h30;
            4'h4:    pat = 7'h19;
            4'h5:    pat = 7'h12;
            4'h6:    pat = 7'h02;
            4'h7:    pat = 7'h78;
            4'h8:    pat = 7'h00;
            4'h9:    pat = 7'h10;
            4'hA:    pat = 7'h08;
            4'hB:    pat = 7'h03;
            4'hC:    pat = 7'h46;
            4'hD:    pat = 7'h21;
            4'hE:    pat = 7'h06;
            default: pat = 7'h0E;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg_display_scan_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and
// debounced level, with a registered one-cycle pulse on each accepted rise.
//   clk   : system clock
//   clr   : asynchronous active-low reset
//   btn   : raw asynchronous button, active-high
//   rise  : one-cycle pulse when the debounced level goes 0 -> 1
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic clr,
    input  logic btn,
    output logic rise
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic [CNT_W-1:0] cnt_q;

    // The counter only runs while the synchronized level disagrees with the
    // accepted level; any return to agreement (a bounce) clears it.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            rise    <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            rise    <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q   <= '0;
                level_q <= sync2_q;
                rise    <= sync2_q;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/seg_display_scan.sv
// Multiplexed 8-digit hex display of one of four CPU words, chosen by a
// debounced push-button. The shown word is snapshotted at each frame start.
//   clk          : system clock
//   clr          : asynchronous active-low reset
//   leddata      : source 0, syscall LED word
//   count_all    : source 1, total cycle count
//   count_branch : source 2, taken-branch count
//   count_jmp    : source 3, jump count
//   sel_btn      : raw button, active-high; each press advances the source
//   an           : digit enables, active-low, bit 0 = rightmost digit
//   seg          : cathodes, active-low, {dp, g,f,e,d,c,b,a}
//   src_sel      : currently selected source
module seg_display_scan
    import seg_display_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 100000,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [DATA_W-1:0]     leddata,
    input  logic [DATA_W-1:0]     count_all,
    input  logic [DATA_W-1:0]     count_branch,
    input  logic [DATA_W-1:0]     count_jmp,
    input  logic                  sel_btn,
    output logic [NUM_DIGITS-1:0] an,
    output logic [7:0]            seg,
    output logic [SRC_W-1:0]      src_sel
);

    localparam int unsigned PSC_W = $clog2(SCAN_DIV);
    localparam logic [PSC_W-1:0]      PSC_LAST = PSC_W'(SCAN_DIV - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);

    logic                  btn_rise;
    logic [PSC_W-1:0]      psc_q;
    logic [DIGIT_W-1:0]    digit_q;
    logic [SRC_W-1:0]      src_q;
    logic [DATA_W-1:0]     snap_q;
    logic [NUM_DIGITS-1:0] an_q;
    seg_t                  seg_q;

    logic [DATA_W-1:0]     src_word;
    logic                  frame_start;
    logic [NIBBLE_W-1:0]   nibble;
    seg_t                  seg_next;
    logic [NUM_DIGITS-1:0] an_next;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk  (clk),
        .clr  (clr),
        .btn  (sel_btn),
        .rise (btn_rise)
    );

    // Source mux, frame-start detect and digit decode.
    always_comb begin
        src_word = leddata;
        case (src_e'(src_q))
            SRC_LED:    src_word = leddata;
            SRC_ALL:    src_word = count_all;
            SRC_BRANCH: src_word = count_branch;
            default:    src_word = count_jmp;
        endcase

        frame_start   = (psc_q == '0) && (digit_q == '0);
        nibble        = snap_q[{digit_q, 2'b00} +: NIBBLE_W];
        seg_next.segs = hex_to_seg(nibble);
        // The lit decimal point marks which source is on display.
        seg_next.dp   = (digit_q != {1'b0, src_q});
        an_next       = ~(AN_ONE << digit_q);
    end

    // Source select and scan timing; a source change restarts the frame and
    // takes priority over a coincident prescaler wrap.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            src_q   <= '0;
            psc_q   <= '0;
            digit_q <= '0;
        end else if (btn_rise) begin
            src_q   <= src_q + SRC_W'(1);
            psc_q   <= '0;
            digit_q <= '0;
        end else if (psc_q == PSC_LAST) begin
            psc_q   <= '0;
            digit_q <= digit_q + DIGIT_W'(1);
        end else begin
            psc_q   <= psc_q + PSC_W'(1);
        end
    end

    // Frame snapshot so a frame never mixes old and new digits.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            snap_q <= '0;
        end else if (frame_start) begin
            snap_q <= src_word;
        end
    end

    // Registered display drive.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            an_q  <= '1;
            seg_q <= '1;
        end else begin
            an_q  <= an_next;
            seg_q <= seg_next;
        end
    end

    assign an      = an_q;
    assign seg     = seg_q;
    assign src_sel = src_q;

endmodule

// File: doc/seg_display_scan.md
# seg_display_scan

Output stage downstream of the pipelined CPU core: consumes the core's `Leddata`, `Count_all`, `Count_branch` and `Count_jmp` words and shows one of them as eight hex digits on the board's multiplexed 7-segment display. A debounced push-button cycles the displayed source. Each frame's value is snapshotted so digits never tear mid-scan.

## Interface
Parameters:
- `SCAN_DIV`, 100000: clk cycles each digit stays lit; must be ≥ 2.
- `DEBOUNCE_CYCLES`, 1000000: consecutive stable synchronized cycles needed to accept a button level; must be ≥ 2.

Ports:
- `clk`  in  1: single system clock, same clock as the CPU core.
- `clr`  in  1: asynchronous, active-low reset.
- `leddata`  in  32: source 0, the core's syscall LED word.
- `count_all`  in  32: source 1, total cycle count.
- `count_branch`  in  32: source 2, taken-branch count.
- `count_jmp`  in  32: source 3, jump count.
- `sel_btn`  in  1: raw, asynchronous, bouncy button; active-high.
- `an`  out  8: digit enables, active-low; bit i = digit i, where digit 0 is the rightmost.
- `seg`  out  8: cathodes, active-low; `seg[6:0]` = g,f,e,d,c,b,a; `seg[7]` = decimal point.
- `src_sel`  out  2: currently selected source.

## Operation
- Button path:
  - `sel_btn` passes through a 2-flop synchronizer.
  - A debounce counter clears on any change of the synchronized level.
  - When the counter reaches `DEBOUNCE_CYCLES`, the debounced state takes the synchronized level.
  - A 0→1 transition of the debounced state advances `src_sel` by one: 0→1→2→3→0, wrapping.
  - Bounces shorter than `DEBOUNCE_CYCLES` produce no advance.
  - Holding the button produces exactly one advance.
- Scan:
  - Prescaler counts 0..`SCAN_DIV`-1 and wraps.
  - On wrap, `digit` (3 bits) increments and wraps 7→0.
- Snapshot:
  - The 32-bit `snap` loads the source selected by `src_sel` on the cycle where prescaler==0 and `digit`==0 (frame start).
  - `snap` holds for the rest of the frame.
- Source change: in the cycle `src_sel` advances, the prescaler and `digit` are forced to 0, so `snap` loads the new source on the following cycle. If a source change and a prescaler wrap occur in the same cycle, the source change wins.
- Decode:
  - Digit i shows nibble `snap[4i+3:4i]` as hex, using the standard patterns, for example:
    - 0 = 7'h40
    - 1 = 7'h79
    - 8 = 7'h00
    - A = 7'h08
    - F = 7'h0E
  - Decimal point `seg[7]` is low only on digit index == `src_sel`, which identifies the source.
  - `an` = ~(8'b1 << `digit`).
- Reset (`clr` low, asynchronous):
  - `an`=8'hFF, `seg`=8'hFF, `src_sel`=0.
  - `snap`=0, `digit`=0, prescaler=0.
  - Debounce state=0, debounce counter=0, synchronizer=0.
  - Reset asserted mid-frame or mid-debounce aborts immediately. After release, the first cycle is a frame start.

## Timing
- `an` and `seg` are registered and change exactly one cycle after `digit` changes. Only one `an` bit is low at any time after reset.
- Button latency from a clean rising edge on `sel_btn` to `src_sel` change is 2 (synchronizer) + `DEBOUNCE_CYCLES` + 1 cycles.
- Source change to first new digit on `an`/`seg`: 3 cycles (force, snapshot, output register).
- A full frame is 8×`SCAN_DIV` cycles. Input changes mid-frame become visible only at the next frame start.

## Structure
- Package `seg_display_pkg`:
  - Source encodings `SRC_LED`=0, `SRC_ALL`=1, `SRC_BRANCH`=2, `SRC_JMP`=3.
  - The 16-entry hex-to-segment constant table / function.
- Sub-module `btn_debounce`: synchronizer, counter, debounced level and a one-cycle rise pulse. It is parameterized by `DEBOUNCE_CYCLES`.
- The top holds the prescaler, `digit`, `src_sel`, `snap`, decode and output registers.

## Test plan
Bench parameters: `SCAN_DIV`=4, `DEBOUNCE_CYCLES`=8.
- Reset: hold `clr` low with random inputs → `an`=8'hFF, `seg`=8'hFF, `src_sel`=0. After release, digit 0 is lit within 2 cycles.
- Scan: `leddata`=32'h1234_5678 → digit 0 `seg[6:0]`=7'h00 (8), digit 7 =7'h79 (1), digit 0 dp low, others dp high. Each `an` is low for exactly 4 cycles, in order 0..7.
- Bounce: toggle `sel_btn` every 3 cycles for 40 cycles, then hold high → exactly one advance, to `src_sel`=1, occurring 11 cycles after the final rise.
- Wrap: four clean presses → `src_sel` goes 1,2,3,0. With `count_jmp`=32'hFFFF_FFFF and `src_sel`=3, all digits show 7'h0E and the dp is on digit 3.
- No tearing: change `leddata` from 32'h0 to 32'hAAAA_AAAA mid-frame → remaining digits of that frame show 0. The next frame shows 7'h08 on all digits.
- Reset mid-operation: assert `clr` during a debounce count at `src_sel`=2 → immediate reset values. A button held high across reset release gives one advance to 1 after the debounce latency.
